// File: rtl/uart_fifo_pkg.sv
// Shared defaults and helpers for the uart transmit byte queue.
package uart_fifo_pkg;

  localparam int UART_FIFO_WIDTH = 8;
  localparam int UART_FIFO_DEPTH = 16;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read for fall-through output.
module fifo_ram
  import uart_fifo_pkg::*;
#(
  parameter int WIDTH = UART_FIFO_WIDTH,
  parameter int DEPTH = UART_FIFO_DEPTH
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [ptr_w(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]        wdata,
  input  logic [ptr_w(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]        rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte queue between bridge_tx and uart_tx using start/done handshakes on both sides.
// Optional occupancy / high-water status ports: define UART_TX_FIFO_STATUS_EN.
module uart_tx_fifo
  import uart_fifo_pkg::*;
#(
  parameter int WIDTH = UART_FIFO_WIDTH,
  parameter int DEPTH = UART_FIFO_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WIDTH-1:0]        data_i,
  input  logic                    start_i,
  output logic                    done_o,
  output logic [WIDTH-1:0]        data_o,
  output logic                    start_o,
  input  logic                    done_i
`ifdef UART_TX_FIFO_STATUS_EN
  ,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic [$clog2(DEPTH):0]  max_count_o
`endif
);

  localparam int            PW       = ptr_w(DEPTH);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          push;
  logic          pop;

  assign done_o  = (count != FULL_CNT);
  assign start_o = (count != '0);
  assign push    = start_i && done_o;
  assign pop     = start_o && done_i;

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (data_i),
    .raddr (rd_ptr),
    .rdata (data_o)
  );

  // Pointers wrap by natural overflow; count carries the extra bit for full vs empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

`ifdef UART_TX_FIFO_STATUS_EN
  logic [PW:0] max_count;

  always_ff @(posedge clk) begin
    if (!rst_n) max_count <= '0;
    else if (count > max_count) max_count <= count;
  end

  assign count_o     = count;
  assign max_count_o = max_count;
`endif

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte queue between `bridge_tx` and `uart_tx` on the host-facing transmit path. It accepts bytes from `bridge_tx` as fast as it presents them, so a full 7-byte read response is absorbed in a few clocks. It then drains the bytes to `uart_tx` at line rate. Both sides use the existing start/done byte handshake, so the block drops into the `btx`→`utx` connection without changes to either neighbour.

## Interface
Parameters:
- `WIDTH`, 8 — byte width.
- `DEPTH`, 16 — entries; must be a power of two, ≥ 2.

Ports:
- `clk`  input  1 — single clock; all logic on rising edge.
- `rst_n`  input  1 — reset; one clock, synchronous, active-low.
- `data_i`  input  WIDTH — byte from `bridge_tx`.
- `start_i`  input  1 — upstream has a byte on `data_i`.
- `done_o`  output  1 — upstream ready. A byte is accepted on any edge where `start_i && done_o`.
- `data_o`  output  WIDTH — head-of-queue byte to `uart_tx`.
- `start_o`  output  1 — queue non-empty; request to `uart_tx`.
- `done_i`  input  1 — `uart_tx` idle/ready. A byte is popped on any edge where `start_o && done_i`.
- `count_o`  output  $clog2(DEPTH)+1 — occupancy (only with `UART_TX_FIFO_STATUS_EN`).
- `max_count_o`  output  $clog2(DEPTH)+1 — high-water mark (only with `UART_TX_FIFO_STATUS_EN`).

## Operation
- Storage: DEPTH×WIDTH array, plus write pointer `wr_ptr` and read pointer `rd_ptr`, each $clog2(DEPTH) bits.
  - Pointers wrap modulo DEPTH by natural overflow.
  - Occupancy `count` is $clog2(DEPTH)+1 bits, so full (`count == DEPTH`) and empty (`count == 0`) are distinguishable.
- `done_o = (count != DEPTH)`; combinational from registered `count`.
- `start_o = (count != 0)`; combinational from registered `count`.
- `data_o = mem[rd_ptr]` (first-word fall-through). Stable while `start_o` is high and no pop occurs.
- Push: `mem[wr_ptr] <= data_i`, `wr_ptr` increments.
- Pop: `rd_ptr` increments.
- Count update:
  - push only: +1
  - pop only: −1
  - push and pop in the same cycle (legal whenever 0 < count < DEPTH): unchanged
- Full: push refused because `done_o` is low. Upstream `bridge_tx` stalls on `done_i`, so no byte is lost. No overflow path exists.
- Empty: `start_o` is low, so no pop. There is no empty-bypass: a byte pushed into an empty queue is not forwarded in the same cycle.
- Byte order is strictly FIFO. Bytes are never modified or reordered.
- `start_o` may stay high across consecutive bytes. `uart_tx` chains the next byte when its `done_o` rises; this block pops on that edge.

## Timing
- Reset, on an edge with `rst_n == 0`: `wr_ptr`, `rd_ptr` and `count` go to 0. From the next cycle `done_o == 1`, `start_o == 0` and `data_o` is don't-care; `count_o == 0` and `max_count_o == 0`. Memory contents are not reset.
- Reset mid-operation discards all queued bytes. A byte `uart_tx` is already shifting completes on the line; it is not repeated.
- `rst_n` has priority over push and pop in the same cycle.
- Latency: a byte pushed at edge N gives `start_o == 1` and valid `data_o` from cycle N+1. Minimum input-to-output latency is 1 clock.
- Throughput: upstream 1 byte/clk until full; downstream limited by `uart_tx`, one byte per (10 × CLOCKS_PER_BAUD).
- `done_o` falls in the cycle after the DEPTH-th push. It rises in the cycle after the first pop from full.

## Configuration
- `UART_TX_FIFO_STATUS_EN` defined:
  - `count_o` and `max_count_o` ports exist.
  - `count_o` mirrors `count`.
  - `max_count_o` is registered, updates to `count` whenever `count > max_count_o`, and clears only on reset. Useful for sizing DEPTH against Manta response bursts.
- Undefined: both ports and the high-water register are absent. Queue behaviour is identical.

## Structure
- Shared package `uart_fifo_pkg`:
  - `localparam` defaults `UART_FIFO_WIDTH = 8` and `UART_FIFO_DEPTH = 16`.
  - Function `ptr_w(depth)` returning $clog2(depth).
- One sub-module, `fifo_ram`: simple dual-port array with synchronous write and asynchronous read. Pointers, count and handshake stay in `uart_tx_fifo`.

## Test plan
- Reset, then push "D","1","2","3","4",CR,LF on consecutive clocks with `done_i = 1` → all 7 accepted (`done_o` held high); `uart_tx`-side pops emit the same 7 bytes in order.
- Push 16 bytes 0x00–0x0F with `done_i = 0` → `done_o` low from cycle after the 16th push. A 17th byte 0xAA held on `start_i` is not accepted until the first pop; output order ends …0x0F, 0xAA.
- Fill to 3 bytes, then push and pop in the same cycle for 50 cycles → `count` stays 3 and output is the exact input sequence.
- Wrap: 40 push/pop pairs through DEPTH=16 with an incrementing pattern → no byte lost or duplicated across the pointer wrap.
- Assert `rst_n = 0` for 1 clock with 5 bytes queued → next cycle `start_o == 0`, `done_o == 1`; next pushed byte 0x55 is the next byte popped.
- With `UART_TX_FIFO_STATUS_EN`: peak occupancy 9, then drain → `max_count_o == 9` and `count_o == 0`.
